e3_to_bin: RTL

Digit-serial Excess-3 to binary decoder that sits downstream of the E3 adder. It takes a packed multi-digit Excess-3 word, such as the 4-digit E3 sum, over a valid/ready handshake. It converts the word most-significant digit first at one digit per cycle and returns the unsigned binary value over a second valid/ready handshake. It is used wherever E3 results must feed binary datapaths or display/compare logic.

---
 rtl/e3_pkg.sv | 18 +
 rtl/e3_digit_dec.sv | 23 ++
 rtl/e3_to_bin.sv | 118 +++++++++++
 3 files changed

// File: rtl/e3_pkg.sv
// Excess-3 constants and the FSM state type shared by the E3 adder and its decoders.
package e3_pkg;

    localparam logic [3:0] E3_BIAS = 4'd3;
    localparam logic [3:0] E3_MIN  = 4'b0011;
    localparam logic [3:0] E3_MAX  = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } e3_dec_state_t;

    function automatic logic e3_digit_ok(input logic [3:0] d);
        return (d >= E3_MIN) && (d <= E3_MAX);
    endfunction

endpackage

// File: rtl/e3_digit_dec.sv
// Combinational single-digit Excess-3 decode; the invalid flag exists only
// when E3_DEC_CHECK_EN is defined, otherwise digits wrap arithmetically.
module e3_digit_dec
    import e3_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] val_o
`ifdef E3_DEC_CHECK_EN
    ,
    output logic       invalid_o
`endif
);

`ifdef E3_DEC_CHECK_EN
    always_comb begin
        invalid_o = !e3_digit_ok(digit_i);
        val_o     = invalid_o ? 4'd0 : (digit_i - E3_BIAS);
    end
`else
    assign val_o = digit_i - E3_BIAS;
`endif

endmodule

// File: rtl/e3_to_bin.sv
// Digit-serial Excess-3 to binary decoder, MSD first, one digit per cycle.
// Optional digit range checking is enabled with the E3_DEC_CHECK_EN macro.
module e3_to_bin
    import e3_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_e3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_bin,
    output logic                out_err
);

    localparam int IN_W  = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    e3_dec_state_t      state_q;
    logic [IN_W-1:0]    sr_q;
    logic [OUT_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;
    logic [OUT_W-1:0]   out_bin_q;

    logic [3:0]         msd;
    logic [3:0]         dval;
    logic [OUT_W-1:0]   acc_d;

    assign msd = sr_q[IN_W-1 -: 4];

`ifdef E3_DEC_CHECK_EN
    logic dinv;
    logic err_q;
    logic err_d;
    logic out_err_q;

    e3_digit_dec u_dec (
        .digit_i   (msd),
        .val_o     (dval),
        .invalid_o (dinv)
    );

    assign err_d = err_q | dinv;
`else
    e3_digit_dec u_dec (
        .digit_i (msd),
        .val_o   (dval)
    );
`endif

    // acc*10 as (acc<<3)+(acc<<1), wrapping modulo 2^OUT_W
    assign acc_d = (acc_q << 3) + (acc_q << 1) + {{(OUT_W-4){1'b0}}, dval};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
`ifdef E3_DEC_CHECK_EN
            out_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sr_q    <= in_e3;
                        acc_q   <= '0;
                        cnt_q   <= CNT_W'(DIGITS - 1);
`ifdef E3_DEC_CHECK_EN
                        err_q   <= 1'b0;
`endif
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    acc_q <= acc_d;
                    sr_q  <= sr_q << 4;
`ifdef E3_DEC_CHECK_EN
                    err_q <= err_d;
`endif
                    if (cnt_q == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_bin_q   <= acc_d;
`ifdef E3_DEC_CHECK_EN
                        out_err_q   <= err_d;
`endif
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by rst so nothing is accepted while reset is held.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
`ifdef E3_DEC_CHECK_EN
    assign out_err   = out_err_q;
`else
    assign out_err   = 1'b0;
`endif

endmodule
